// File: rtl/fun_root_mul.sv
// fun_root_mul: result = a * floor(root(b)), with cube or square root selected per operation.
// The root is found one bit per cycle, MSB first, by restoring digit recurrence. It is then
// multiplied by a one bit per cycle, MSB first, with shift-add. Latency is 2K cycles, where K is
// the root bit count for the selected mode.
module fun_root_mul #(
  parameter int unsigned W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             a_i,
  input  logic [W-1:0]             b_i,
  input  logic                     mode_i,
  input  logic                     start,
  output logic [W+(W+1)/2-1:0]     result,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned RW = (W + 1) / 2;   // root width, sized for the square-root case
  localparam int unsigned PW = W + RW;        // exact product width
  localparam int unsigned KC = (W + 2) / 3;   // cube-root bit count
  localparam int unsigned IW = $clog2(RW);    // iteration index width
  localparam int unsigned SW = IW + 2;        // shift amount width (up to 3*index)
  localparam int unsigned TW = 2 * W + 4;     // trial-term width, holds 3y(y+1)+1 comfortably

  typedef enum logic [1:0] {StIdle, StRoot, StMul} state_e;

  state_e          r_state, w_state_d;
  logic [W-1:0]    r_a, w_a_d;
  logic [W-1:0]    r_rem, w_rem_d;
  logic [RW-1:0]   r_y, w_y_d;
  logic [IW-1:0]   r_cnt, w_cnt_d;
  logic            r_mode, w_mode_d;
  logic [PW-1:0]   r_acc, w_acc_d;
  logic [PW-1:0]   r_result, w_result_d;
  logic            r_done, w_done_d;

  logic [RW-1:0]   w_y2;
  logic [TW-1:0]   w_y2w;
  logic [TW-1:0]   w_t;
  logic [SW-1:0]   w_shamt;
  logic            w_take;
  logic            w_ybit;
  logic [PW-1:0]   w_acc_nx;
  logic [IW-1:0]   w_klast;

  // Root-step and multiply-step datapath
  always_comb begin
    w_y2    = r_y << 1;
    w_y2w   = TW'(w_y2);
    // Trial increment from (2y)^k to (2y+1)^k: square 4y+1, cube 3*2y*(2y+1)+1
    w_t     = r_mode ? ((w_y2w << 1) + TW'(1))
                     : ((TW'(3) * w_y2w * (w_y2w + TW'(1))) + TW'(1));
    w_shamt = r_mode ? (SW'(r_cnt) << 1) : (SW'(r_cnt) * SW'(3));
    w_take  = ((TW'(r_rem) >> w_shamt) >= w_t);
    w_ybit  = r_y[r_cnt];
    w_acc_nx = (r_acc << 1) + (w_ybit ? PW'(r_a) : '0);
    w_klast = r_mode ? IW'(RW - 1) : IW'(KC - 1);
  end

  // Next-state logic for the IDLE -> ROOT -> MUL sequence
  always_comb begin
    w_state_d  = r_state;
    w_a_d      = r_a;
    w_rem_d    = r_rem;
    w_y_d      = r_y;
    w_cnt_d    = r_cnt;
    w_mode_d   = r_mode;
    w_acc_d    = r_acc;
    w_result_d = r_result;
    w_done_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_a_d     = a_i;
          w_rem_d   = b_i;
          w_mode_d  = mode_i;
          w_y_d     = '0;
          w_cnt_d   = mode_i ? IW'(RW - 1) : IW'(KC - 1);
          w_state_d = StRoot;
        end
      end
      StRoot: begin
        if (w_take) begin
          w_rem_d = r_rem - W'(w_t << w_shamt);
          w_y_d   = w_y2 + RW'(1);
        end else begin
          w_y_d   = w_y2;
        end
        if (r_cnt == '0) begin
          w_state_d = StMul;
          w_cnt_d   = w_klast;
          w_acc_d   = '0;
        end else begin
          w_cnt_d   = r_cnt - IW'(1);
        end
      end
      StMul: begin
        w_acc_d = w_acc_nx;
        if (r_cnt == '0) begin
          w_state_d  = StIdle;
          w_result_d = w_acc_nx;
          w_done_d   = 1'b1;
        end else begin
          w_cnt_d    = r_cnt - IW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_rem    <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_a      <= w_a_d;
      r_rem    <= w_rem_d;
      r_y      <= w_y_d;
      r_cnt    <= w_cnt_d;
      r_mode   <= w_mode_d;
      r_acc    <= w_acc_d;
      r_result <= w_result_d;
      r_done   <= w_done_d;
    end
  end

  assign busy   = (r_state != StIdle);
  assign done   = r_done;
  assign result = r_result;

endmodule
